bcd_conv_arbiter: RTL

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

---
 rtl/bcd_conv_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among NUM_REQ requesters.
// Optional macro BCD_ARB_TIMEOUT_EN adds a WAIT-state watchdog that resets the converter.
module bcd_conv_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BIN_WIDTH  = 8,
  parameter int DEC_DIGITS = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic [NUM_REQ-1:0]              Req,
  input  logic [NUM_REQ*BIN_WIDTH-1:0]    ReqData,
  output logic [NUM_REQ-1:0]              Grant,
  output logic [NUM_REQ-1:0]              RespValid,
  output logic [DEC_DIGITS*4-1:0]         RespBCD,
  output logic                            RespErr,
  output logic [BIN_WIDTH-1:0]            ConvDataBin,
  output logic                            ConvStart,
  input  logic [DEC_DIGITS*4-1:0]         ConvDataBCD,
  input  logic                            ConvDone,
  output logic                            ConvRst_n
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [PW-1:0] idx);
    one_hot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [1:0]              state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           win_q, win_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
  logic [DEC_DIGITS*4-1:0] resp_bcd_q, resp_bcd_d;
  logic [BIN_WIDTH-1:0]    conv_data_q, conv_data_d;
  logic                    conv_start_q, conv_start_d;
  logic [PW-1:0]           sel_idx_s;
  logic                    any_req_s;
`ifdef BCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    resp_err_q, resp_err_d;
  logic                    conv_rst_n_q, conv_rst_n_d;
`endif

  // Round-robin pick: scan downward so the lowest offset from ptr wins last.
  always_comb begin
    any_req_s = |Req;
    sel_idx_s = {PW{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sel_idx_s = Req[(int'(ptr_q) + i) % NUM_REQ] ? PW'((int'(ptr_q) + i) % NUM_REQ) : sel_idx_s;
    end
  end

  // Next-state and registered-output logic of the IDLE/WAIT/RESP controller.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    grant_d      = grant_q;
    resp_valid_d = resp_valid_q;
    resp_bcd_d   = resp_bcd_q;
    conv_data_d  = conv_data_q;
    conv_start_d = conv_start_q;
`ifdef BCD_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_err_d   = resp_err_q;
    conv_rst_n_d = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          state_d      = S_WAIT;
          win_d        = sel_idx_s;
          grant_d      = one_hot(sel_idx_s);
          conv_data_d  = ReqData[sel_idx_s*BIN_WIDTH +: BIN_WIDTH];
          conv_start_d = 1'b1;
`ifdef BCD_ARB_TIMEOUT_EN
          cnt_d        = {CW{1'b0}};
`endif
        end else begin
          grant_d      = {NUM_REQ{1'b0}};
          conv_start_d = 1'b0;
        end
      end
      S_WAIT: begin
        grant_d      = {NUM_REQ{1'b0}};
        conv_start_d = 1'b0;
        if (ConvDone) begin
          resp_bcd_d   = ConvDataBCD;
          resp_valid_d = one_hot(win_q);
          state_d      = S_RESP;
`ifdef BCD_ARB_TIMEOUT_EN
          resp_err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Watchdog expiry: answer with an error and kick the converter.
          resp_bcd_d   = {(DEC_DIGITS*4){1'b0}};
          resp_valid_d = one_hot(win_q);
          resp_err_d   = 1'b1;
          conv_rst_n_d = 1'b0;
          state_d      = S_RESP;
        end else begin
          cnt_d        = cnt_q + CW'(1);
        end
`else
        end else begin
          state_d      = S_WAIT;
        end
`endif
      end
      S_RESP: begin
        resp_valid_d = {NUM_REQ{1'b0}};
        ptr_d        = (win_q == PW'(NUM_REQ - 1)) ? {PW{1'b0}} : win_q + PW'(1);
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= {PW{1'b0}};
      win_q        <= {PW{1'b0}};
      grant_q      <= {NUM_REQ{1'b0}};
      resp_valid_q <= {NUM_REQ{1'b0}};
      resp_bcd_q   <= {(DEC_DIGITS*4){1'b0}};
      conv_data_q  <= {BIN_WIDTH{1'b0}};
      conv_start_q <= 1'b0;
`ifdef BCD_ARB_TIMEOUT_EN
      cnt_q        <= {CW{1'b0}};
      resp_err_q   <= 1'b0;
      conv_rst_n_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      resp_bcd_q   <= resp_bcd_d;
      conv_data_q  <= conv_data_d;
      conv_start_q <= conv_start_d;
`ifdef BCD_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
      conv_rst_n_q <= conv_rst_n_d;
`endif
    end
  end

  assign Grant       = grant_q;
  assign RespValid   = resp_valid_q;
  assign RespBCD     = resp_bcd_q;
  assign ConvDataBin = conv_data_q;
  assign ConvStart   = conv_start_q;
`ifdef BCD_ARB_TIMEOUT_EN
  assign RespErr     = resp_err_q;
  assign ConvRst_n   = conv_rst_n_q;
`else
  assign RespErr     = 1'b0;
  assign ConvRst_n   = 1'b1;
`endif

endmodule
